// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage issue/collect controller for DIV/DIVU.
// Hands one operation at a time to a pipelined radix-2 array divider. Resolves
// divide-by-zero locally. An annulled operation is drained: its result is
// discarded when it comes back from the divider.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no operation outstanding; accepts a new request
//   BYZERO | divisor was zero; the result is formed locally next edge
//   BUSY   | operation issued; waiting for the divider result or a timeout
//   DONE   | result presented on o_result/o_ready until EX drops i_start
//   DRAIN  | annulled operation still in the divider; discard its result
module div_issue_ctrl #(
    parameter int N_DATA        = 32,
    parameter int LATENCY       = 32,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_signed,
    input  logic [N_DATA-1:0]     i_opdata1,
    input  logic [N_DATA-1:0]     i_opdata2,
    input  logic                  i_annul,
    output logic                  o_stall,
    output logic                  o_ready,
    output logic [2*N_DATA-1:0]   o_result,
    output logic                  o_err,
    output logic                  o_divstart,
    output logic                  o_div_signed,
    output logic [N_DATA-1:0]     o_dividend,
    output logic [N_DATA-1:0]     o_divisor,
    input  logic [N_DATA-1:0]     i_quotient,
    input  logic [N_DATA-1:0]     i_remainder,
    input  logic                  i_res_vld
);

    localparam int CNT_LIMIT = LATENCY + TIMEOUT_SLACK;
    localparam int CW        = $clog2(CNT_LIMIT + 1);

    // The counter holds 0 in the o_divstart cycle. Timeout fires on the edge
    // where it would step to CNT_LIMIT, so o_err rises CNT_LIMIT cycles after
    // the issue pulse. A result arriving on that same edge still wins.
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LIMIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BYZERO = 3'd1;
    localparam logic [2:0] S_BUSY   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          timeout;

    assign timeout = (cnt == CNT_LAST);

    // Sequencing FSM with registered divider handshake and result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            o_ready      <= 1'b0;
            o_result     <= '0;
            o_err        <= 1'b0;
            o_divstart   <= 1'b0;
            o_div_signed <= 1'b0;
            o_dividend   <= '0;
            o_divisor    <= '0;
        end else begin
            o_divstart <= 1'b0;
            o_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_annul) begin
                        if (i_opdata2 == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            o_divstart   <= 1'b1;
                            o_div_signed <= i_signed;
                            o_dividend   <= i_opdata1;
                            o_divisor    <= i_opdata2;
                            cnt          <= '0;
                            state        <= S_BUSY;
                        end
                    end
                end
                S_BYZERO: begin
                    if (i_annul) begin
                        state <= S_IDLE;
                    end else begin
                        o_result <= {i_opdata1, {N_DATA{1'b1}}};
                        o_ready  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (i_res_vld) begin
                        if (i_annul) begin
                            state <= S_IDLE;
                        end else begin
                            o_result <= {i_remainder, i_quotient};
                            o_ready  <= 1'b1;
                            state    <= S_DONE;
                        end
                    end else if (i_annul) begin
                        state <= S_DRAIN;
                    end else if (timeout) begin
                        o_err    <= 1'b1;
                        o_result <= '0;
                        o_ready  <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt + CW'(1);
                    if (i_res_vld) begin
                        state <= S_IDLE;
                    end else if (timeout) begin
                        o_err <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!i_start || i_annul) begin
                        o_ready  <= 1'b0;
                        o_result <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall request: held while an operation is being formed or awaited; a flush always releases it.
    always_comb begin
        o_stall = 1'b0;
        if (!i_annul) begin
            case (state)
                S_IDLE:   o_stall = i_start;
                S_BYZERO: o_stall = 1'b1;
                S_BUSY:   o_stall = 1'b1;
                S_DRAIN:  o_stall = i_start;
                default:  o_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural pipelined divider model.
module tb_div_issue_ctrl;

    localparam int LATENCY = 32;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic        i_signed;
    logic [31:0] i_opdata1;
    logic [31:0] i_opdata2;
    logic        i_annul;
    logic        o_stall;
    logic        o_ready;
    logic [63:0] o_result;
    logic        o_err;
    logic        o_divstart;
    logic        o_div_signed;
    logic [31:0] o_dividend;
    logic [31:0] o_divisor;
    logic [31:0] i_quotient;
    logic [31:0] i_remainder;
    logic        i_res_vld;

    int n_vec;
    int n_err;
    int edge_cnt;
    int s;
    int cyc;
    int starts;
    int gaps;

    logic              model_mute;
    logic [LATENCY-1:0] vld_pipe;
    logic [63:0]       res_pipe [LATENCY];

    div_issue_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_signed     (i_signed),
        .i_opdata1    (i_opdata1),
        .i_opdata2    (i_opdata2),
        .i_annul      (i_annul),
        .o_stall      (o_stall),
        .o_ready      (o_ready),
        .o_result     (o_result),
        .o_err        (o_err),
        .o_divstart   (o_divstart),
        .o_div_signed (o_div_signed),
        .o_dividend   (o_dividend),
        .o_divisor    (o_divisor),
        .i_quotient   (i_quotient),
        .i_remainder  (i_remainder),
        .i_res_vld    (i_res_vld)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Divider reference: returns {remainder, quotient}, sign-corrected.
    function automatic logic [63:0] div_model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (sg) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Pipelined divider model: result valid LATENCY cycles after the start pulse.
    always @(posedge i_clk) begin
        vld_pipe <= {vld_pipe[LATENCY-2:0], o_divstart};
        res_pipe[0] <= div_model(o_div_signed, o_dividend, o_divisor);
        for (int i = 1; i < LATENCY; i++) res_pipe[i] <= res_pipe[i-1];
    end

    assign i_res_vld   = vld_pipe[LATENCY-1] & ~model_mute;
    assign i_quotient  = res_pipe[LATENCY-1][31:0];
    assign i_remainder = res_pipe[LATENCY-1][63:32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        edge_cnt++;
    endtask

    // Applies the start edge and runs until o_ready; cyc counts edges from the start edge.
    task automatic run_op(output int c, output int st);
        c  = 0;
        st = 0;
        do begin
            step();
            c++;
            if (o_divstart) st++;
        end while (!o_ready && c < 80);
        if (!o_ready) c = -1;
    endtask

    task automatic finish_op(input string tag);
        i_start = 1'b0;
        step();
        chk({tag, "_ready_drop"}, {63'h0, o_ready}, 64'h0);
        chk({tag, "_result_clr"}, o_result, 64'h0);
    endtask

    task automatic set_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
        i_signed  = sg;
        i_opdata1 = a;
        i_opdata2 = b;
        i_start   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; edge_cnt = 0;
        i_rst_n = 1'b0; i_start = 1'b0; i_signed = 1'b0;
        i_opdata1 = '0; i_opdata2 = '0; i_annul = 1'b0; model_mute = 1'b0;
        #3;
        chk("rst_ready",  {63'h0, o_ready}, 64'h0);
        chk("rst_result", o_result, 64'h0);
        chk("rst_start",  {63'h0, o_divstart}, 64'h0);
        chk("rst_ops",    {o_dividend, o_divisor}, 64'h0);
        step(); step();
        i_rst_n = 1'b1;
        step();

        // 1: unsigned 7/2
        set_op(1'b0, 32'd7, 32'd2);
        #1;
        chk("u_stall_idle", {63'h0, o_stall}, 64'h1);
        run_op(cyc, starts);
        chk("u_latency", 64'(cyc), 64'(LATENCY + 2));
        chk("u_starts",  64'(starts), 64'd1);
        chk("u_result",  o_result, 64'h00000001_00000003);
        chk("u_ops",     {o_dividend, o_divisor}, {32'd7, 32'd2});
        chk("u_sgn",     {63'h0, o_div_signed}, 64'h0);
        chk("u_stall_done", {63'h0, o_stall}, 64'h0);
        step();
        chk("u_hold", {63'h0, o_ready}, 64'h1);
        finish_op("u");

        // 2: signed -7/2 and overflow case
        set_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(cyc, starts);
        chk("s_latency", 64'(cyc), 64'(LATENCY + 2));
        chk("s_result",  o_result, 64'hFFFFFFFF_FFFFFFFD);
        chk("s_sgn",     {63'h0, o_div_signed}, 64'h1);
        finish_op("s");
        set_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(cyc, starts);
        chk("ovf_result", o_result, 64'h00000000_80000000);
        finish_op("ovf");

        // 3: divide by zero, unsigned then signed
        set_op(1'b0, 32'h1234_5678, 32'h0);
        run_op(cyc, starts);
        chk("z_u_latency", 64'(cyc), 64'd2);
        chk("z_u_starts",  64'(starts), 64'd0);
        chk("z_u_result",  o_result, 64'h12345678_FFFFFFFF);
        finish_op("z_u");
        set_op(1'b1, 32'h1234_5678, 32'h0);
        run_op(cyc, starts);
        chk("z_s_latency", 64'(cyc), 64'd2);
        chk("z_s_starts",  64'(starts), 64'd0);
        chk("z_s_result",  o_result, 64'h12345678_FFFFFFFF);
        finish_op("z_s");

        // 4: annul at cycle 10, new request 100/7 at cycle 12 waits for the drain
        set_op(1'b0, 32'd50, 32'd5);
        s = edge_cnt;
        step();
        while (edge_cnt - s < 10) step();
        i_annul = 1'b1;
        i_start = 1'b0;
        #1;
        chk("an_stall_forced", {63'h0, o_stall}, 64'h0);
        step();
        i_annul = 1'b0;
        step();
        set_op(1'b0, 32'd100, 32'd7);
        #1;
        chk("an_stall_drain", {63'h0, o_stall}, 64'h1);
        gaps = 0;
        while (!o_divstart && edge_cnt - s < 100) begin
            step();
            if (!o_stall || o_ready) gaps++;
        end
        chk("an_stall_held", 64'(gaps), 64'd0);
        chk("an_issue_cycle", 64'(edge_cnt - s), 64'(LATENCY + 3));
        while (!o_ready && edge_cnt - s < 120) step();
        chk("an_ready_cycle", 64'(edge_cnt - s), 64'(2 * LATENCY + 4));
        chk("an_result", o_result, 64'h00000002_0000000E);
        finish_op("an");

        // 5a: annul coincident with result
        set_op(1'b0, 32'd9, 32'd3);
        s = edge_cnt;
        step();
        while (!i_res_vld && edge_cnt - s < 60) step();
        chk("co_vld_cycle", 64'(edge_cnt - s), 64'(LATENCY + 1));
        i_annul = 1'b1;
        i_start = 1'b0;
        step();
        i_annul = 1'b0;
        chk("co_ready", {63'h0, o_ready}, 64'h0);
        chk("co_result", o_result, 64'h0);
        set_op(1'b0, 32'd1, 32'd1);
        step();
        chk("co_idle_issue", {63'h0, o_divstart}, 64'h1);
        s = edge_cnt;
        while (!o_ready && edge_cnt - s < 60) step();
        chk("co_next_result", o_result, 64'h00000000_00000001);
        finish_op("co");

        // 5b: divider never answers -> timeout
        model_mute = 1'b1;
        set_op(1'b0, 32'd10, 32'd3);
        run_op(cyc, starts);
        chk("to_cycle",  64'(cyc), 64'(LATENCY + 5));
        chk("to_err",    {63'h0, o_err}, 64'h1);
        chk("to_result", o_result, 64'h0);
        step();
        chk("to_err_pulse", {63'h0, o_err}, 64'h0);
        chk("to_ready_held", {63'h0, o_ready}, 64'h1);
        finish_op("to");
        model_mute = 1'b0;

        // 6: async reset mid-BUSY, stray result ignored, then a normal op
        set_op(1'b1, 32'd20, 32'd4);
        s = edge_cnt;
        step();
        while (edge_cnt - s < 5) step();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("ar_ops",     {o_dividend, o_divisor}, 64'h0);
        chk("ar_ctrl",    {60'h0, o_ready, o_err, o_divstart, o_div_signed}, 64'h0);
        chk("ar_result",  o_result, 64'h0);
        i_start = 1'b0;
        step(); step();
        i_rst_n = 1'b1;
        while (!i_res_vld && edge_cnt - s < 60) step();
        chk("ar_stray_cycle", 64'(edge_cnt - s), 64'(LATENCY + 1));
        step();
        chk("ar_stray_ready", {63'h0, o_ready}, 64'h0);
        chk("ar_stray_result", o_result, 64'h0);
        set_op(1'b1, 32'd21, 32'd4);
        run_op(cyc, starts);
        chk("ar_next_latency", 64'(cyc), 64'(LATENCY + 2));
        chk("ar_next_result", o_result, 64'h00000001_00000005);
        finish_op("ar");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
